writeback_unit: RTL and testbench

Final pipeline stage. It accepts retiring results from the memory stage and drives the register-file, condition-code and vector-register write ports into decode. It also supplies the writeback-stage destination used for dependency checking, and the branch-redirect PC to fetch. Vector results are written one 16-bit component per cycle, with backpressure to the memory stage while a write is in progress.

---
 rtl/writeback_unit_pkg.sv | 23 ++
 rtl/writeback_unit_cc_gen.sv | 24 ++
 rtl/writeback_unit.sv | 156 +++++++++++++++
 tb/tb_writeback_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit_pkg
// Description : Shared widths, condition-code and FSM encodings for writeback.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_unit_pkg;

    localparam int REG_WIDTH     = 16;
    localparam int VREG_WIDTH    = 64;
    localparam int VREG_ID_WIDTH = 6;
    localparam int PC_WIDTH      = 16;
    localparam int NUM_COMPS     = VREG_WIDTH / REG_WIDTH;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    localparam logic [0:0] WB_IDLE = 1'b0;
    localparam logic [0:0] WB_VEC  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/writeback_unit_cc_gen.sv
`default_nettype none
// ============================================================================
// Module      : cc_gen
// Description : Combinational {N,Z,P} condition code from a scalar result.
// Revision    : 1.0 - initial release
// ============================================================================
module cc_gen
    import writeback_unit_pkg::*;
(
    input  logic [REG_WIDTH-1:0] i_result,
    output logic [2:0]           o_cc
);

    always_comb begin
        o_cc = CC_P;
        if (i_result[REG_WIDTH-1]) begin
            o_cc = CC_N;
        end else if (i_result == '0) begin
            o_cc = CC_Z;
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit
// Description : Final pipeline stage; scalar/CC/branch writeback and
//               one-component-per-cycle vector register writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int CNT_WIDTH = 32
)
(
    input  logic                     I_CLOCK,
    input  logic                     I_RESET_N,
    input  logic                     I_LOCK,
    input  logic                     I_MW_Valid,
    input  logic [3:0]               I_DestRegIdx,
    input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
    input  logic [REG_WIDTH-1:0]     I_Result,
    input  logic [VREG_WIDTH-1:0]    I_VecResult,
    input  logic                     I_RegWrite,
    input  logic                     I_VRegWrite,
    input  logic                     I_CCWrite,
    input  logic                     I_BranchTaken,
    input  logic [PC_WIDTH-1:0]      I_BranchPC,
    output logic                     O_WBStall,
    output logic                     O_RegWEn,
    output logic [3:0]               O_WriteBackRegIdx,
    output logic [REG_WIDTH-1:0]     O_WriteBackData,
    output logic                     O_CCWEn,
    output logic [2:0]               O_CCValue,
    output logic                     O_VRegWEn,
    output logic [VREG_ID_WIDTH-1:0] O_WriteBackVRegIdx,
    output logic [1:0]               O_WriteBackCompIdx,
    output logic [REG_WIDTH-1:0]     O_VecCompData,
    output logic                     O_WriteBackPCEn,
    output logic [PC_WIDTH-1:0]      O_WriteBackPC,
    output logic [3:0]               O_WBDestRegIdx,
    output logic                     O_WBDestWrite,
    output logic [CNT_WIDTH-1:0]     O_RetireCount
);

    logic [0:0]               r_state;
    logic [1:0]               r_comp;
    logic [VREG_WIDTH-1:0]    r_vec_hold;
    logic [VREG_ID_WIDTH-1:0] r_vidx_hold;

    logic                     w_accept;
    logic [2:0]               w_cc;
    logic [1:0]               w_next_comp;
    logic [REG_WIDTH-1:0]     w_comp_data;
    logic [REG_WIDTH-1:0]     w_comps [NUM_COMPS];

    assign w_accept    = I_LOCK & I_MW_Valid & ~O_WBStall;
    assign w_next_comp = r_comp + 2'd1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COMPS; gi++) begin : g_comp
            assign w_comps[gi] = r_vec_hold[gi*REG_WIDTH +: REG_WIDTH];
        end
    endgenerate

    assign w_comp_data = w_comps[w_next_comp];

    cc_gen u_cc_gen (
        .i_result (I_Result),
        .o_cc     (w_cc)
    );

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_state            <= WB_IDLE;
            r_comp             <= '0;
            r_vec_hold         <= '0;
            r_vidx_hold        <= '0;
            O_WBStall          <= 1'b0;
            O_RegWEn           <= 1'b0;
            O_WriteBackRegIdx  <= '0;
            O_WriteBackData    <= '0;
            O_CCWEn            <= 1'b0;
            O_CCValue          <= '0;
            O_VRegWEn          <= 1'b0;
            O_WriteBackVRegIdx <= '0;
            O_WriteBackCompIdx <= '0;
            O_VecCompData      <= '0;
            O_WriteBackPCEn    <= 1'b0;
            O_WriteBackPC      <= '0;
            O_WBDestRegIdx     <= '0;
            O_WBDestWrite      <= 1'b0;
            O_RetireCount      <= '0;
        end else begin
            // Strobes are pulses: cleared unless this edge produces a write.
            O_RegWEn        <= 1'b0;
            O_CCWEn         <= 1'b0;
            O_VRegWEn       <= 1'b0;
            O_WriteBackPCEn <= 1'b0;
            O_WBDestWrite   <= 1'b0;

            if (w_accept) begin
                O_RetireCount <= O_RetireCount + CNT_WIDTH'(1);
            end

            case (r_state)
                WB_IDLE: begin
                    if (w_accept) begin
                        O_RegWEn        <= I_RegWrite;
                        O_WBDestWrite   <= I_RegWrite;
                        O_CCWEn         <= I_CCWrite;
                        O_WriteBackPCEn <= I_BranchTaken;
                        if (I_RegWrite) begin
                            O_WriteBackRegIdx <= I_DestRegIdx;
                            O_WriteBackData   <= I_Result;
                            O_WBDestRegIdx    <= I_DestRegIdx;
                        end
                        if (I_CCWrite) begin
                            O_CCValue <= w_cc;
                        end
                        if (I_BranchTaken) begin
                            O_WriteBackPC <= I_BranchPC;
                        end
                        // Component 0 goes out straight from the input; the
                        // hold register feeds components 1..3.
                        if (I_VRegWrite) begin
                            r_state            <= WB_VEC;
                            r_comp             <= 2'd0;
                            r_vec_hold         <= I_VecResult;
                            r_vidx_hold        <= I_DestVRegIdx;
                            O_VRegWEn          <= 1'b1;
                            O_WriteBackVRegIdx <= I_DestVRegIdx;
                            O_WriteBackCompIdx <= 2'd0;
                            O_VecCompData      <= I_VecResult[REG_WIDTH-1:0];
                            O_WBStall          <= 1'b1;
                        end
                    end
                end
                WB_VEC: begin
                    if (I_LOCK) begin
                        r_comp             <= w_next_comp;
                        O_VRegWEn          <= 1'b1;
                        O_WriteBackVRegIdx <= r_vidx_hold;
                        O_WriteBackCompIdx <= w_next_comp;
                        O_VecCompData      <= w_comp_data;
                        if (w_next_comp == 2'd3) begin
                            r_state   <= WB_IDLE;
                            O_WBStall <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_unit
// Description : Randomized scoreboard bench for writeback_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    localparam int TB_CNT_W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        I_LOCK = 1'b0, I_MW_Valid = 1'b0;
    logic [3:0]  I_DestRegIdx = '0;
    logic [5:0]  I_DestVRegIdx = '0;
    logic [15:0] I_Result = '0, I_BranchPC = '0;
    logic [63:0] I_VecResult = '0;
    logic        I_RegWrite = 1'b0, I_VRegWrite = 1'b0, I_CCWrite = 1'b0, I_BranchTaken = 1'b0;

    logic        O_WBStall, O_RegWEn, O_CCWEn, O_VRegWEn, O_WriteBackPCEn, O_WBDestWrite;
    logic [3:0]  O_WriteBackRegIdx, O_WBDestRegIdx;
    logic [15:0] O_WriteBackData, O_VecCompData, O_WriteBackPC;
    logic [2:0]  O_CCValue;
    logic [5:0]  O_WriteBackVRegIdx;
    logic [1:0]  O_WriteBackCompIdx;
    logic [TB_CNT_W-1:0] O_RetireCount;

    always #5 clk = ~clk;

    writeback_unit #(.CNT_WIDTH(TB_CNT_W)) dut (
        .I_CLOCK(clk), .I_RESET_N(rst_n), .I_LOCK(I_LOCK), .I_MW_Valid(I_MW_Valid),
        .I_DestRegIdx(I_DestRegIdx), .I_DestVRegIdx(I_DestVRegIdx), .I_Result(I_Result),
        .I_VecResult(I_VecResult), .I_RegWrite(I_RegWrite), .I_VRegWrite(I_VRegWrite),
        .I_CCWrite(I_CCWrite), .I_BranchTaken(I_BranchTaken), .I_BranchPC(I_BranchPC),
        .O_WBStall(O_WBStall), .O_RegWEn(O_RegWEn), .O_WriteBackRegIdx(O_WriteBackRegIdx),
        .O_WriteBackData(O_WriteBackData), .O_CCWEn(O_CCWEn), .O_CCValue(O_CCValue),
        .O_VRegWEn(O_VRegWEn), .O_WriteBackVRegIdx(O_WriteBackVRegIdx),
        .O_WriteBackCompIdx(O_WriteBackCompIdx), .O_VecCompData(O_VecCompData),
        .O_WriteBackPCEn(O_WriteBackPCEn), .O_WriteBackPC(O_WriteBackPC),
        .O_WBDestRegIdx(O_WBDestRegIdx), .O_WBDestWrite(O_WBDestWrite),
        .O_RetireCount(O_RetireCount)
    );

    logic [80:0] w_all;
    assign w_all = {O_WBStall, O_RegWEn, O_WriteBackRegIdx, O_WriteBackData, O_CCWEn, O_CCValue,
                    O_VRegWEn, O_WriteBackVRegIdx, O_WriteBackCompIdx, O_VecCompData,
                    O_WriteBackPCEn, O_WriteBackPC, O_WBDestRegIdx, O_WBDestWrite, O_RetireCount};

    typedef struct packed {
        logic        lock, valid, rw, vw, ccw, br;
        logic [3:0]  ridx;
        logic [5:0]  vidx;
        logic [15:0] res, bpc;
        logic [63:0] vec;
    } txn_t;

    typedef struct {
        int          stamp;
        logic        reg_en, cc_en, v_en, pc_en;
        logic [3:0]  reg_idx;
        logic [15:0] reg_data, vdata, pc;
        logic [5:0]  vidx;
        logic [1:0]  comp;
    } ev_t;

    typedef struct {
        int                  stamp;
        logic                stall, dwr;
        logic [TB_CNT_W-1:0] count;
        logic [2:0]          cc;
    } st_t;

    ev_t ev_q[$];
    st_t st_q[$];
    int  tests = 0;
    int  fails = 0;
    int  edges = 0;

    // Reference model: components still owed to the register file, plus counters.
    int                  m_pending = 0;
    logic [63:0]         m_vec = '0;
    logic [5:0]          m_vidx = '0;
    logic [TB_CNT_W-1:0] m_count = '0;
    logic [2:0]          m_cc = '0;

    always @(posedge clk) edges <= edges + 1;

    function automatic logic [2:0] ref_cc(input logic [15:0] r);
        if ($signed(r) < 0) return 3'b100;
        if (r == 16'd0) return 3'b010;
        return 3'b001;
    endfunction

    task automatic model(input txn_t t);
        ev_t e;
        st_t s;
        e = '{stamp: edges, reg_en: 1'b0, cc_en: 1'b0, v_en: 1'b0, pc_en: 1'b0,
              reg_idx: '0, reg_data: '0, vdata: '0, pc: '0, vidx: '0, comp: '0};
        if (t.lock) begin
            if (m_pending > 0) begin
                e.v_en  = 1'b1;
                e.vidx  = m_vidx;
                e.comp  = 2'(4 - m_pending);
                e.vdata = m_vec[16*(4-m_pending) +: 16];
                m_pending--;
            end else if (t.valid) begin
                m_count++;
                e.reg_en = t.rw;  e.reg_idx = t.ridx; e.reg_data = t.res;
                e.cc_en  = t.ccw; e.pc_en = t.br;     e.pc = t.bpc;
                if (t.ccw) m_cc = ref_cc(t.res);
                if (t.vw) begin
                    m_vec = t.vec; m_vidx = t.vidx; m_pending = 3;
                    e.v_en = 1'b1; e.vidx = t.vidx; e.comp = 2'd0; e.vdata = t.vec[15:0];
                end
            end
        end
        if (e.reg_en | e.cc_en | e.v_en | e.pc_en) ev_q.push_back(e);
        s = '{stamp: edges, stall: (m_pending > 0), dwr: e.reg_en, count: m_count, cc: m_cc};
        st_q.push_back(s);
    endtask

    task automatic step(input txn_t t);
        @(negedge clk);
        I_LOCK = t.lock; I_MW_Valid = t.valid; I_RegWrite = t.rw; I_VRegWrite = t.vw;
        I_CCWrite = t.ccw; I_BranchTaken = t.br; I_DestRegIdx = t.ridx;
        I_DestVRegIdx = t.vidx; I_Result = t.res; I_BranchPC = t.bpc; I_VecResult = t.vec;
        @(posedge clk);
        #1;
        model(t);
    endtask

    function automatic txn_t idle(input logic lock);
        txn_t t;
        t = '0;
        t.lock = lock;
        return t;
    endfunction

    function automatic txn_t scal(input logic [3:0] idx, input logic [15:0] res);
        txn_t t;
        t = '0;
        t.lock = 1'b1; t.valid = 1'b1; t.rw = 1'b1; t.ccw = 1'b1; t.ridx = idx; t.res = res;
        return t;
    endfunction

    function automatic txn_t vecw(input logic [5:0] vidx, input logic [63:0] v);
        txn_t t;
        t = '0;
        t.lock = 1'b1; t.valid = 1'b1; t.vw = 1'b1; t.vidx = vidx; t.vec = v;
        return t;
    endfunction

    task automatic mon_check();
        ev_t e;
        st_t s;
        logic any, ok;
        any = O_RegWEn | O_CCWEn | O_VRegWEn | O_WriteBackPCEn;
        while (ev_q.size() > 0 && ev_q[0].stamp < edges) begin
            e = ev_q.pop_front();
            tests++; fails++;
            $display("FAIL missing_write edge %0d: no strobe seen, required reg=%b cc=%b v=%b pc=%b",
                     e.stamp, e.reg_en, e.cc_en, e.v_en, e.pc_en);
        end
        if (any) begin
            tests++;
            if (ev_q.size() == 0 || ev_q[0].stamp != edges) begin
                fails++;
                $display("FAIL unexpected_strobe edge %0d: reg=%b cc=%b v=%b pc=%b, required none",
                         edges, O_RegWEn, O_CCWEn, O_VRegWEn, O_WriteBackPCEn);
            end else begin
                e = ev_q.pop_front();
                ok = (O_RegWEn === e.reg_en) && (O_CCWEn === e.cc_en) &&
                     (O_VRegWEn === e.v_en) && (O_WriteBackPCEn === e.pc_en) &&
                     (O_WBDestWrite === e.reg_en) &&
                     (!e.reg_en || (O_WriteBackRegIdx === e.reg_idx && O_WriteBackData === e.reg_data &&
                                    O_WBDestRegIdx === e.reg_idx)) &&
                     (!e.v_en || (O_WriteBackVRegIdx === e.vidx && O_WriteBackCompIdx === e.comp &&
                                  O_VecCompData === e.vdata)) &&
                     (!e.pc_en || O_WriteBackPC === e.pc);
                if (!ok) begin
                    fails++;
                    $display("FAIL write_event edge %0d: got reg=%b/%h/%h cc=%b v=%b/%0d/%0d/%h pc=%b/%h dest=%b/%h, required reg=%b/%h/%h cc=%b v=%b/%0d/%0d/%h pc=%b/%h",
                             edges, O_RegWEn, O_WriteBackRegIdx, O_WriteBackData, O_CCWEn,
                             O_VRegWEn, O_WriteBackVRegIdx, O_WriteBackCompIdx, O_VecCompData,
                             O_WriteBackPCEn, O_WriteBackPC, O_WBDestWrite, O_WBDestRegIdx,
                             e.reg_en, e.reg_idx, e.reg_data, e.cc_en, e.v_en, e.vidx, e.comp,
                             e.vdata, e.pc_en, e.pc);
                end
            end
        end
        while (st_q.size() > 0 && st_q[0].stamp < edges) void'(st_q.pop_front());
        if (st_q.size() > 0 && st_q[0].stamp == edges) begin
            s = st_q.pop_front();
            tests++;
            if (O_WBStall !== s.stall || O_RetireCount !== s.count || O_CCValue !== s.cc ||
                O_WBDestWrite !== s.dwr) begin
                fails++;
                $display("FAIL status edge %0d: stall=%b count=%0d cc=%b dwr=%b, required stall=%b count=%0d cc=%b dwr=%b",
                         edges, O_WBStall, O_RetireCount, O_CCValue, O_WBDestWrite,
                         s.stall, s.count, s.cc, s.dwr);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) mon_check();
    end

    task automatic check_zero(input string name);
        tests++;
        if (w_all !== '0) begin
            fails++;
            $display("FAIL %s: outputs=%h, required all zero", name, w_all);
        end
    endtask

    initial begin
        txn_t t;
        #1;
        check_zero("reset_state");
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Negative result, then zero and positive back to back.
        step(scal(4'd3, 16'h8000));
        step(idle(1'b1));
        step(scal(4'd1, 16'h0000));
        step(scal(4'd2, 16'h0005));
        step(idle(1'b1));

        // Vector write with a scalar waiting behind it.
        step(vecw(6'd7, 64'h0004_0003_0002_0001));
        repeat (4) step(scal(4'd9, 16'h1234));
        repeat (2) step(idle(1'b1));

        // Branch redirect together with a vector write.
        t = vecw(6'd12, 64'hDEAD_BEEF_CAFE_F00D);
        t.br = 1'b1; t.bpc = 16'h0040; t.rw = 1'b1; t.ridx = 4'd5; t.res = 16'h7FFF; t.ccw = 1'b1;
        step(t);
        repeat (4) step(idle(1'b1));

        // Lock dropped after component 1.
        step(vecw(6'd20, 64'h4444_3333_2222_1111));
        step(idle(1'b1));
        repeat (2) step(idle(1'b0));
        repeat (3) step(idle(1'b1));

        // Reset after component 1 aborts the remaining components.
        step(vecw(6'd33, 64'h8888_7777_6666_5555));
        step(idle(1'b1));
        @(negedge clk);
        #1;
        I_MW_Valid = 1'b0; I_VRegWrite = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_vector");
        ev_q.delete(); st_q.delete();
        m_pending = 0; m_count = '0; m_cc = '0;
        @(posedge clk);
        #1;
        check_zero("no_component2_after_reset");
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) step(idle(1'b1));

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            t = '0;
            t.lock  = ($urandom_range(0, 99) < 85);
            t.valid = ($urandom_range(0, 99) < 70);
            t.rw    = 1'($urandom);
            t.vw    = ($urandom_range(0, 3) == 0);
            t.ccw   = 1'($urandom);
            t.br    = ($urandom_range(0, 7) == 0);
            t.ridx  = 4'($urandom);
            t.vidx  = 6'($urandom);
            t.res   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            t.bpc   = 16'($urandom);
            t.vec   = {$urandom, $urandom};
            step(t);
        end
        repeat (4) step(idle(1'b1));

        // Retire counter wrap using stores (no write flags).
        t = '0;
        t.lock = 1'b1; t.valid = 1'b1;
        while (m_count != '1) step(t);
        step(t);
        tests++;
        if (O_RetireCount !== '0) begin
            fails++;
            $display("FAIL counter_wrap: count=%0d, required 0", O_RetireCount);
        end

        repeat (6) step(idle(1'b1));
        @(negedge clk);
        #1;
        tests++;
        if (ev_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d writes outstanding, required 0", ev_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
